// File: rtl/forward_unit_pipelined.sv
// Forwarding and load-use hazard unit for an ID -> EX -> MEM -> WB pipeline.
// Tracks destinations through EX/MEM/WB and sources through EX; counts load-use stalls.
module forward_unit_pipelined #(
  parameter int REG_W       = 3,
  parameter int NUM_SRC     = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ext_stall,
  input  logic                     flush,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_we,
  input  logic                     id_load,
  input  logic [NUM_SRC*REG_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  output logic [2*NUM_SRC-1:0]     fwd,
  output logic                     load_use_stall,
  output logic [CNT_W-1:0]         stall_count
);

  localparam logic [1:0] FWD_MEM = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_RF  = 2'd2;

  // EX entry
  logic [REG_W-1:0]         ex_rd;
  logic                     ex_we;
  logic                     ex_load;
  logic [NUM_SRC*REG_W-1:0] ex_rs;
  logic [NUM_SRC-1:0]       ex_used;
  // MEM and WB entries
  logic [REG_W-1:0]         mem_rd;
  logic                     mem_we;
  logic [REG_W-1:0]         wb_rd;
  logic                     wb_we;

  logic [NUM_SRC-1:0]       id_hit;
  logic                     ex_rd_zero;
  logic                     bubble;

  // Forward selects depend only on registered state, never on the id_* inputs.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_W-1:0] rs;
    logic             live;
    logic             mem_hit;
    logic             wb_hit;

    assign rs      = ex_rs[g*REG_W +: REG_W];
    assign live    = ex_used[g] && !((ZERO_REG_EN != 0) && (rs == '0));
    assign mem_hit = live && mem_we && (mem_rd == rs);
    assign wb_hit  = live && wb_we && (wb_rd == rs);
    assign fwd[2*g +: 2] = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);

    assign id_hit[g] = id_rs_used[g] && (id_rs[g*REG_W +: REG_W] == ex_rd);
  end

  assign ex_rd_zero     = (ZERO_REG_EN != 0) && (ex_rd == '0);
  assign load_use_stall = ex_we && ex_load && (|id_hit) && !ex_rd_zero &&
                          !flush && !ext_stall && !reset;
  assign bubble         = flush || load_use_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd       <= '0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      ex_rs       <= '0;
      ex_used     <= '0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
      stall_count <= '0;
    end else if (!ext_stall) begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      if (bubble) begin
        ex_rd   <= '0;
        ex_we   <= 1'b0;
        ex_load <= 1'b0;
        ex_rs   <= '0;
        ex_used <= '0;
      end else begin
        ex_rd   <= id_rd;
        ex_we   <= id_we;
        ex_load <= id_load;
        ex_rs   <= id_rs;
        ex_used <= id_rs_used;
      end
      // Saturates at all-ones so a long run never wraps back to a small value.
      if (load_use_stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
